// File: rtl/uart_msg_scheduler.sv
// Two-requester round-robin message sequencer for the shared ROM + UART transmit path.
// Walks the granted message's ROM addresses and holds start_o until busy_i acknowledges it.
module uart_msg_scheduler #(
  parameter int ADDR_W      = 4,
  parameter int LEN_W       = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        req_i,
  input  logic [ADDR_W-1:0] base0_i,
  input  logic [ADDR_W-1:0] base1_i,
  input  logic [LEN_W-1:0]  len0_i,
  input  logic [LEN_W-1:0]  len1_i,
  input  logic              busy_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              start_o,
  output logic [1:0]        grant_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic              idle_o
);

  localparam int TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int TMO_LAST = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 1 : 0;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LOAD, S_START, S_WAIT, S_NEXT, S_GAP
  } state_t;

  state_t             state;
  logic [1:0]         pend;
  logic               last;
  logic [LEN_W-1:0]   rem;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               win;
  logic [LEN_W-1:0]   win_len;

  // Both pending: the one not served last wins; reset leaves last=1 so requester 0 goes first.
  always_comb begin
    win = 1'b0;
    if (pend == 2'b11) win = ~last;
    else               win = pend[1] & ~pend[0];
    win_len = win ? len1_i : len0_i;
  end

  assign idle_o = (state == S_IDLE) && (pend == 2'b00);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      pend    <= 2'b00;
      last    <= 1'b1;
      rem     <= '0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
      addr_o  <= '0;
      start_o <= 1'b0;
      grant_o <= 2'b00;
      done_o  <= 2'b00;
      err_o   <= 1'b0;
    end else begin
      done_o <= 2'b00;
      pend   <= pend | req_i;
      case (state)
        S_IDLE: if (pend != 2'b00) state <= S_ARB;
        S_ARB: begin
          // A request landing on the grant cycle re-arms the flag.
          pend    <= (pend & ~(2'b01 << win)) | req_i;
          last    <= win;
          grant_o <= 2'b01 << win;
          addr_o  <= win ? base1_i : base0_i;
          rem     <= win_len;
          gap_cnt <= '0;
          if (win_len == '0) begin
            done_o <= 2'b01 << win;
            state  <= S_GAP;
          end else begin
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          start_o <= 1'b1;
          tmo_cnt <= '0;
          state   <= S_START;
        end
        S_START: begin
          if (busy_i) begin
            start_o <= 1'b0;
            state   <= S_WAIT;
          end else if (tmo_cnt == TMO_W'(TMO_LAST)) begin
            start_o <= 1'b0;
            err_o   <= 1'b1;
            done_o  <= grant_o;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT: if (!busy_i) state <= S_NEXT;
        S_NEXT: begin
          rem    <= rem - 1'b1;
          addr_o <= addr_o + 1'b1;
          if (rem == LEN_W'(1)) begin
            done_o  <= grant_o;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            state   <= S_LOAD;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            grant_o <= 2'b00;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Directed bench for uart_msg_scheduler: message-level model of grants, byte addresses,
// done/err/idle and handshake latencies, checked every cycle, plus literal scenario checks.
module tb_uart_msg_scheduler;
  localparam int AW   = 4;
  localparam int LW   = 4;
  localparam int TMO  = 255;
  localparam int GAP  = 2;
  localparam int GAPL = (GAP > 0) ? GAP : 1;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [1:0]    req_i = 2'b00;
  logic [AW-1:0] base0_i = '0, base1_i = '0;
  logic [LW-1:0] len0_i = '0, len1_i = '0;
  logic          busy_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic          start_o, err_o, idle_o;
  logic [1:0]    grant_o, done_o;

  uart_msg_scheduler #(.ADDR_W(AW), .LEN_W(LW), .ACK_TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i),
    .base0_i(base0_i), .base1_i(base1_i), .len0_i(len0_i), .len1_i(len1_i),
    .busy_i(busy_i), .addr_o(addr_o), .start_o(start_o), .grant_o(grant_o),
    .done_o(done_o), .err_o(err_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  int            cyc = 0;
  logic [1:0]    req_s;
  logic          busy_s, rst_s;
  logic [AW-1:0] b0_s, b1_s;
  logic [LW-1:0] l0_s, l1_s;
  always @(posedge clk) begin
    cyc++;
    req_s = req_i; busy_s = busy_i; rst_s = reset_i;
    b0_s = base0_i; b1_s = base1_i; l0_s = len0_i; l1_s = len1_i;
  end

  // Message-level model.
  logic [1:0]    m_pend;
  logic          m_last, m_err, m_tmo, m_w;
  logic [AW-1:0] m_addr;
  int            m_left, t_grant, t_rel, t_done, hold, last_hold, n_msg_done;
  bit            first_byte, wait_rel;
  logic          p_start;
  logic [1:0]    p_grant, p_done;
  logic [1:0]    gq[$];
  int            aq[$];
  int            n_start = 0, n_dn = 0;

  always @(negedge clk) begin
    if (rst_s) begin
      m_pend = 2'b00; m_last = 1'b1; m_err = 1'b0; m_tmo = 1'b0;
      p_start = 1'b0; p_grant = 2'b00; p_done = 2'b00;
      hold = 0; wait_rel = 0; n_msg_done = 0; first_byte = 0;
      chk("rst_addr", addr_o, 0);   chk("rst_start", start_o, 0);
      chk("rst_grant", grant_o, 0); chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);     chk("rst_idle", idle_o, 1);
    end else begin
      if (p_grant == 2'b00 && grant_o != 2'b00) begin
        m_w = (m_pend == 2'b11) ? ~m_last : (m_pend == 2'b10);
        chk("grant_had_pending", m_pend != 2'b00, 1);
        chk("grant_winner", grant_o, 2'b01 << m_w);
        m_pend[m_w] = 1'b0; m_last = m_w;
        m_addr = m_w ? b1_s : b0_s;
        m_left = m_w ? l1_s : l0_s;
        t_grant = cyc; first_byte = 1; m_tmo = 0; n_msg_done = 0; wait_rel = 0;
        gq.push_back(grant_o);
      end
      m_pend = m_pend | req_s;
      if (!p_start && start_o) begin
        chk("start_has_bytes", m_left != 0, 1);
        chk("start_addr", addr_o, m_addr);
        chk("start_granted", grant_o != 2'b00, 1);
        if (first_byte) chk("start_lat_first", cyc - t_grant, 1);
        else            chk("start_lat_next", cyc - t_rel, 2);
        first_byte = 0; hold = 0; n_start++;
        aq.push_back(int'(addr_o));
      end
      if (start_o) hold++;
      if (p_start && !start_o) begin
        last_hold = hold;
        if (busy_s) begin
          m_addr = m_addr + 1'b1; m_left--; wait_rel = 1;
        end else begin
          chk("timeout_len", hold, TMO);
          m_err = 1'b1; m_tmo = 1'b1; m_left = 0;
        end
      end else if (wait_rel && !busy_s && !start_o) begin
        t_rel = cyc; wait_rel = 0;
      end
      if (done_o != 2'b00) begin
        chk("done_grant", done_o, grant_o);
        chk("done_left", m_left, 0);
        chk("done_pulse", p_done, 0);
        if (first_byte)  chk("done_lat_zero", cyc - t_grant, 0);
        else if (!m_tmo) chk("done_lat", cyc - t_rel, 1);
        t_done = cyc; n_msg_done++; n_dn++;
      end
      if (p_grant != 2'b00 && grant_o == 2'b00) begin
        chk("gap_len", cyc - t_done, GAPL);
        chk("done_per_msg", n_msg_done, 1);
      end
      chk("err", err_o, m_err);
      chk("idle", idle_o, (grant_o == 2'b00) && (m_pend == 2'b00));
      p_start = start_o; p_grant = grant_o; p_done = done_o;
    end
  end

  // UART model: busy rises ack_dly cycles after start, stays for busy_len cycles.
  int ack_dly = 2, busy_len = 10;
  bit uart_on = 1;
  initial forever begin
    @(posedge clk); #1;
    if (uart_on && start_o && !busy_i && !reset_i) begin
      repeat (ack_dly - 1) @(posedge clk);
      #1 busy_i = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 busy_i = 1'b0;
    end
  end

  task automatic pulse(input logic [1:0] r);
    @(posedge clk); #1 req_i = r;
    @(posedge clk); #1 req_i = 2'b00;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (idle_o !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk(name, idle_o, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0;
  endtask

  // exp packs expected addresses as nibbles, first byte in the low nibble.
  task automatic chk_addrs(input string name, input int from, input int n, input logic [31:0] exp);
    chk(name, aq.size() - from, n);
    for (int i = 0; i < n; i++) chk(name, aq[from + i], int'(exp[4*i +: 4]));
  endtask

  int a0, g0, s0, d0, n;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

    // Single request, latency, and base/len changes after grant are ignored.
    base0_i = 4'd3; len0_i = 4'd4;
    a0 = aq.size(); g0 = gq.size(); s0 = n_start; d0 = n_dn;
    pulse(2'b01);
    @(negedge clk); chk("t1_idle_drop", idle_o, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("t1_grant_n2", grant_o, 2'b01); chk("t1_addr_n2", addr_o, 3); chk("t1_start_n2", start_o, 0);
    base0_i = 4'd9; len0_i = 4'd1;
    @(posedge clk); #1 chk("t1_start_n3", start_o, 1);
    wait_idle("t1_idle", 600);
    chk_addrs("t1_addrs", a0, 4, 32'h6543);
    chk("t1_starts", n_start - s0, 4); chk("t1_dones", n_dn - d0, 1);
    chk("t1_grants", gq.size() - g0, 1); chk("t1_grant0", gq[g0], 2'b01);

    // Simultaneous requests after reset: 0 then 1, twice.
    do_reset();
    base0_i = 4'd0; len0_i = 4'd2; base1_i = 4'd8; len1_i = 4'd2;
    a0 = aq.size(); g0 = gq.size();
    pulse(2'b11); wait_idle("t2_idle_a", 800);
    pulse(2'b11); wait_idle("t2_idle_b", 800);
    chk("t2_grants", gq.size() - g0, 4);
    chk("t2_g0", gq[g0], 2'b01);   chk("t2_g1", gq[g0+1], 2'b10);
    chk("t2_g2", gq[g0+2], 2'b01); chk("t2_g3", gq[g0+3], 2'b10);
    chk_addrs("t2_addrs", a0, 8, 32'h98109810);

    // Zero length, then address wrap.
    len0_i = 4'd0;
    s0 = n_start; d0 = n_dn; g0 = gq.size();
    pulse(2'b01); wait_idle("t3_idle_a", 100);
    chk("t3_zero_starts", n_start - s0, 0); chk("t3_zero_done", n_dn - d0, 1);
    chk("t3_zero_grant", gq[g0], 2'b01);
    base1_i = 4'd14; len1_i = 4'd3; a0 = aq.size();
    pulse(2'b10); wait_idle("t3_idle_b", 600);
    chk_addrs("t3_wrap", a0, 3, 32'h0FE);

    // Acknowledge timeout, then a normal message with err held.
    uart_on = 0; base0_i = 4'd5; len0_i = 4'd2;
    s0 = n_start; d0 = n_dn; a0 = aq.size();
    pulse(2'b01); wait_idle("t4_idle_a", 1000);
    chk("t4_err", err_o, 1); chk("t4_starts", n_start - s0, 1);
    chk("t4_hold", last_hold, 255); chk("t4_done", n_dn - d0, 1);
    uart_on = 1; base1_i = 4'd1; len1_i = 4'd1;
    pulse(2'b10); wait_idle("t4_idle_b", 400);
    chk("t4_err_sticky", err_o, 1); chk("t4_starts2", n_start - s0, 2);
    chk("t4_addr2", aq[a0 + 1], 1);

    // Re-request during own message: sent twice.
    base0_i = 4'd4; len0_i = 4'd3;
    a0 = aq.size(); g0 = gq.size(); s0 = n_start;
    pulse(2'b01);
    n = 0;
    while (start_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("t5_started", start_o, 1);
    pulse(2'b01);
    wait_idle("t5_idle", 1200);
    chk("t5_grants", gq.size() - g0, 2);
    chk("t5_g0", gq[g0], 2'b01); chk("t5_g1", gq[g0+1], 2'b01);
    chk("t5_starts", n_start - s0, 6);
    chk_addrs("t5_addrs", a0, 6, 32'h654654);

    // Reset while waiting for busy to fall, with requester 1 pending.
    base0_i = 4'd2; len0_i = 4'd3; len1_i = 4'd2;
    pulse(2'b01);
    n = 0;
    while (!(busy_i === 1'b1 && start_o === 1'b0 && grant_o != 2'b00) && n < 50) begin
      @(negedge clk); n++;
    end
    chk("t6_in_wait", busy_i && !start_o, 1);
    pulse(2'b10);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_idle", idle_o, 1); chk("t6_grant", grant_o, 0);
      chk("t6_start", start_o, 0); chk("t6_err", err_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", nchk, nerr);
    $fatal(1);
  end
endmodule
